// File: rtl/bcd_seg7_scanner.sv
// bcd_seg7_scanner: captures a packed BCD word and scans it onto a multiplexed 7-segment display.
module bcd_seg7_scanner #(
  parameter int DIGITS         = 3,
  parameter int CLK_DIV        = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   bcd,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(CLK_DIV);
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] AN_OFF = AN_ACTIVE_LOW ? '1 : '0;
  logic [4*DIGITS-1:0] cap_q;
  logic [PW-1:0]       pre_q;
  logic [IW-1:0]       idx_q, idx_d;
  logic [6:0]          seg_q, seg_d, pat;
  logic [DIGITS-1:0]   an_q, an_d, oh, lz;
  logic [3:0]          nib;
  logic                tick, z;
  assign tick = pre_q == PW'(CLK_DIV - 1);
  assign idx_d = tick ? (idx_q == IW'(DIGITS - 1) ? '0 : idx_q + IW'(1)) : idx_q;
  assign nib = cap_q[{idx_q, 2'b00} +: 4];
  // lz[i] is set when nibble i and every nibble above it are zero
  always_comb begin
    lz = '0;
    z = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      z = z & (cap_q[4*i +: 4] == 4'd0);
      lz[i] = z;
    end
  end
  always_comb begin
    case (nib)
      4'd0: pat = 7'h3F;
      4'd1: pat = 7'h06;
      4'd2: pat = 7'h5B;
      4'd3: pat = 7'h4F;
      4'd4: pat = 7'h66;
      4'd5: pat = 7'h6D;
      4'd6: pat = 7'h7D;
      4'd7: pat = 7'h07;
      4'd8: pat = 7'h7F;
      4'd9: pat = 7'h6F;
      default: pat = 7'h79;
    endcase
  end
  always_comb begin
    seg_d = (blank_lz && idx_q != '0 && lz[idx_q]) ? 7'h00 : pat;
    seg_d = SEG_ACTIVE_LOW ? ~seg_d : seg_d;
    oh = DIGITS'(1) << idx_q;
    an_d = AN_ACTIVE_LOW ? ~oh : oh;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q <= '0;
      pre_q <= '0;
      idx_q <= '0;
      seg_q <= SEG_OFF;
      an_q  <= AN_OFF;
    end else begin
      if (load) cap_q <= bcd;
      pre_q <= tick ? '0 : pre_q + PW'(1);
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end
  assign seg = seg_q;
  assign an  = an_q;
endmodule

// File: tb/tb_bcd_seg7_scanner.sv
// tb_bcd_seg7_scanner: checks an active-low and an active-high instance against a cycle-count model.
module tb_bcd_seg7_scanner;
  localparam int DIGITS = 3;
  localparam int CLK_DIV = 4;
  logic clk = 1'b0, rst = 1'b1, load = 1'b0, blank_lz = 1'b0;
  logic [11:0] bcd = '0;
  logic [6:0] seg_a, seg_b;
  logic [2:0] an_a, an_b;
  logic [9:0] e_a, e_b;
  logic [6:0] gly [16];
  int n_chk = 0, n_fail = 0;
  int k = 0;
  int mcap = 0;

  bcd_seg7_scanner #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .rst(rst), .bcd(bcd), .load(load), .blank_lz(blank_lz), .seg(seg_a), .an(an_a));
  bcd_seg7_scanner #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .rst(rst), .bcd(bcd), .load(load), .blank_lz(blank_lz), .seg(seg_b), .an(an_b));

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph_of(input int cap, input int i, input logic blz);
    int rest;
    rest = cap >> (4 * i);
    if (blz && i > 0 && rest == 0) return 7'h00;
    return gly[rest % 16];
  endfunction

  // Expected outputs come from state before the edge; the model then applies load.
  task automatic step(input logic ld, input logic [11:0] v);
    int idx;
    logic [6:0] p;
    logic [2:0] oh;
    idx = (k / CLK_DIV) % DIGITS;
    p = glyph_of(mcap, idx, blank_lz);
    oh = 3'b001 << idx;
    e_a = {~p, ~oh};
    e_b = {p, oh};
    load = ld;
    bcd = v;
    @(posedge clk);
    #1;
    load = 1'b0;
    if (ld) mcap = int'(v);
    k++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    k = 0;
    mcap = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk += 2;
    if ({seg_a, an_a} !== {7'h7F, 3'b111}) begin n_fail++; $display("FAIL reset_a got %h exp %h", {seg_a, an_a}, {7'h7F, 3'b111}); end
    if ({seg_b, an_b} !== {7'h00, 3'b000}) begin n_fail++; $display("FAIL reset_b got %h exp %h", {seg_b, an_b}, 10'h000); end
    rst = 1'b0;
    k = 0;
    mcap = 0;
    step(1'b0, 12'h000);
    n_chk += 2;
    if ({seg_a, an_a} !== {7'h40, 3'b110}) begin n_fail++; $display("FAIL first_a got %h exp %h", {seg_a, an_a}, {7'h40, 3'b110}); end
    if ({seg_b, an_b} !== e_b) begin n_fail++; $display("FAIL first_b got %h exp %h", {seg_b, an_b}, e_b); end
  endtask

  task automatic test_scan();
    do_reset();
    step(1'b1, 12'h123);
    for (int i = 0; i < 2 * CLK_DIV * DIGITS; i++) begin
      step(1'b0, 12'h000);
      n_chk += 2;
      if ({seg_a, an_a} !== e_a) begin n_fail++; $display("FAIL scan_a k=%0d got %h exp %h", k, {seg_a, an_a}, e_a); end
      if ({seg_b, an_b} !== e_b) begin n_fail++; $display("FAIL scan_b k=%0d got %h exp %h", k, {seg_b, an_b}, e_b); end
    end
    step(1'b1, 12'h456);
    for (int i = 0; i < CLK_DIV * DIGITS + 1; i++) begin
      step(1'b0, 12'h000);
      n_chk += 2;
      if ({seg_a, an_a} !== e_a) begin n_fail++; $display("FAIL sweep_a k=%0d got %h exp %h", k, {seg_a, an_a}, e_a); end
      if ({seg_b, an_b} !== e_b) begin n_fail++; $display("FAIL sweep_b k=%0d got %h exp %h", k, {seg_b, an_b}, e_b); end
    end
  endtask

  task automatic test_blank();
    logic [11:0] vals [4] = '{12'h007, 12'h007, 12'h000, 12'h0A0};
    logic        blz  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int t = 0; t < 4; t++) begin
      blank_lz = blz[t];
      step(1'b1, vals[t]);
      for (int i = 0; i < CLK_DIV * DIGITS; i++) begin
        step(1'b0, 12'h000);
        n_chk += 2;
        if ({seg_a, an_a} !== e_a) begin n_fail++; $display("FAIL blank_a v=%h got %h exp %h", vals[t], {seg_a, an_a}, e_a); end
        if ({seg_b, an_b} !== e_b) begin n_fail++; $display("FAIL blank_b v=%h got %h exp %h", vals[t], {seg_b, an_b}, e_b); end
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_load_tick();
    bit done = 0;
    step(1'b1, 12'h321);
    for (int i = 0; i < 3 * CLK_DIV; i++) begin
      logic ld;
      ld = !done && (k % CLK_DIV == CLK_DIV - 1);
      if (ld) done = 1;
      step(ld, 12'h987);
      n_chk += 2;
      if ({seg_a, an_a} !== e_a) begin n_fail++; $display("FAIL load_tick_a k=%0d got %h exp %h", k, {seg_a, an_a}, e_a); end
      if ({seg_b, an_b} !== e_b) begin n_fail++; $display("FAIL load_tick_b k=%0d got %h exp %h", k, {seg_b, an_b}, e_b); end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 12'h555);
    repeat (5) step(1'b0, 12'h000);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_chk += 2;
    if ({seg_a, an_a} !== {7'h7F, 3'b111}) begin n_fail++; $display("FAIL mid_reset_a got %h exp %h", {seg_a, an_a}, {7'h7F, 3'b111}); end
    if ({seg_b, an_b} !== 10'h000) begin n_fail++; $display("FAIL mid_reset_b got %h exp %h", {seg_b, an_b}, 10'h000); end
    rst = 1'b0;
    k = 0;
    mcap = 0;
    for (int i = 0; i < CLK_DIV * DIGITS; i++) begin
      step(1'b0, 12'h000);
      n_chk += 2;
      if ({seg_a, an_a} !== e_a) begin n_fail++; $display("FAIL cleared_a k=%0d got %h exp %h", k, {seg_a, an_a}, e_a); end
      if ({seg_b, an_b} !== e_b) begin n_fail++; $display("FAIL cleared_b k=%0d got %h exp %h", k, {seg_b, an_b}, e_b); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (i % 16 == 0) blank_lz = 1'($urandom_range(0, 1));
      step($urandom_range(0, 9) == 0, 12'($urandom >> (4 * $urandom_range(0, 2))));
      n_chk += 2;
      if ({seg_a, an_a} !== e_a) begin n_fail++; $display("FAIL rand_a k=%0d got %h exp %h", k, {seg_a, an_a}, e_a); end
      if ({seg_b, an_b} !== e_b) begin n_fail++; $display("FAIL rand_b k=%0d got %h exp %h", k, {seg_b, an_b}, e_b); end
    end
  endtask

  initial begin
    gly = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79};
    test_reset();
    test_scan();
    test_blank();
    test_load_tick();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
